adc_level_meter: RTL and testbench
==================================

Name: adc_level_meter

Overview:
- Sits directly downstream of the ADC serial interface. Consumes its 12-bit sample stream, boxcar-averages blocks of 2^AVG_LOG2 samples, and renders the result as a bar graph with peak-hold on the 12-bit external LED bank.
- Gives the BCI front end a live signal-level indication without HPS involvement.
- Also exports each block average for logging.

Parameters:
- DATA_W, 12: sample width.
- AVG_LOG2, 4: log2 of samples per average block (1..8).
- LED_N, 12: number of bar LEDs (must be <= 15).
- HOLD_CYCLES, 50000000: clocks the peak marker holds before it starts to decay.
- DECAY_CYCLES, 5000000: clocks per one-step peak decay.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  sample strobe from the ADC stage
- s_data  in  DATA_W  unsigned sample
- enable  in  1  when low, samples are ignored
- clear  in  1  synchronous soft clear of the averager and peak logic
- avg_valid  out  1  one-cycle pulse when avg_data updates
- avg_data  out  DATA_W  latest block average
- leds  out  LED_N  bar graph OR peak marker
- peak_level  out  4  current peak level, 0..LED_N

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - avg_valid=0, avg_data=0, leds=0, peak_level=0.
  - Accumulator and sample counter at 0; FSM in TRACK; hold and decay counters at 0.
- Averager:
  - A sample is accepted when s_valid & enable & !clear.
  - Accumulator width is DATA_W+AVG_LOG2, so it cannot overflow.
  - On acceptance: acc += s_data and cnt++.
  - When the accepted sample is number 2^AVG_LOG2 (cnt == 2^AVG_LOG2-1):
    - avg_data <= (acc+s_data) >> AVG_LOG2 (truncate).
    - avg_valid=1 on the next cycle only.
    - acc and cnt return to 0 in the same edge.
  - Latency: avg_valid rises one clock after the last sample of the block.
  - enable low: s_valid is ignored and the partial block (acc, cnt) is retained.
- Level mapping, one clock after avg_valid:
  - level = min(avg_data >> (DATA_W-4), LED_N).
  - bar[k] = (k < level).
- Peak FSM (TRACK, HOLD, DECAY). It is evaluated on each registered level update and every clock for the counters.
  - Any state, new level > peak: peak <= level, go to HOLD, hold_cnt <= 0. This rule has priority over all counter events in the same cycle.
  - TRACK: peak follows level.
  - HOLD: hold_cnt increments each clock. At HOLD_CYCLES-1, go to DECAY with decay_cnt <= 0.
  - DECAY: decay_cnt increments. At DECAY_CYCLES-1:
    - if peak > level: peak--, decay_cnt <= 0;
    - otherwise peak <= level and go to TRACK.
  - If peak reaches level during DECAY, the FSM goes to TRACK on that same edge.
- Output composition:
  - leds = bar | (peak > 0 ? 1 << (peak-1) : 0).
  - leds and peak_level are registered; they change 2 clocks after the last sample of a block, and also on decay steps.
- clear:
  - Same effect as reset on the averager, FSM, leds and peak_level.
  - Wins over a coincident s_valid; that sample is dropped and no avg_valid is produced.
  - avg_data holds its value.
- Reset mid-block or mid-hold: all state returns to its reset values on that edge; no partial average is emitted.

Decomposition:
- Shared package (adc_meter_pkg) holds:
  - the FSM state enum {TRACK, HOLD, DECAY};
  - LEVEL_W = 4;
  - the function level_of(avg) implementing the shift/clamp.
- One natural sub-module, adc_block_avg: the accumulator, counter and avg_valid generation.
- The peak FSM and LED composition remain in the top module.

Test Plan (AVG_LOG2=2, HOLD_CYCLES=8, DECAY_CYCLES=4, enable=1 unless stated):
1. Samples 0x100, 0x200, 0x300, 0x400 -> avg_valid one clock after the 4th sample, avg_data=0x280. Next clock: level 2, leds=0x003, peak_level=2.
2. Four samples of 0xFFF -> avg_data=0xFFF, level clamps 15->12, leds=0xFFF, peak_level=12.
3. After test 2, four samples of 0x000 -> leds=0x800 for 8 clocks (HOLD). Peak then steps down by one every 4 clocks (leds 0x400, 0x200, ...). After the step to 0: leds=0x000, FSM in TRACK.
4. clear asserted together with the 4th sample of a block -> no avg_valid. Next four samples 0x040 each -> avg_data=0x040, leds=0x000.
5. Samples 0x800, 0x800; then enable=0 with three s_valid pulses of 0xFFF; then enable=1 with 0x800, 0x800 -> avg_data=0x800, leds=0x0FF.
6. reset pulsed for one clock while in HOLD with peak 12 -> next clock leds=0, peak_level=0, FSM in TRACK. The next block average is computed from post-reset samples only.

Source files
------------

// File: rtl/adc_meter_pkg.sv
// adc_meter_pkg
// Shared definitions for the ADC level meter:
//   peak_state_t : peak-hold FSM states (TRACK, HOLD, DECAY)
//   LEVEL_W      : width of a bar-graph level (0..15)
//   level_of()   : maps a block average onto a bar level (top nibble, clamped)
package adc_meter_pkg;

  localparam int LEVEL_W = 4;

  typedef enum logic [1:0] {
    TRACK = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } peak_state_t;

  // The level is the top LEVEL_W bits of the average. It is clamped to the
  // number of LEDs because a 4-bit level can reach 15 while the bank is shorter.
  function automatic logic [LEVEL_W-1:0] level_of(input logic [31:0] avg,
                                                  input int          data_w,
                                                  input int          led_n);
    logic [31:0] raw;
    raw = avg >> (data_w - LEVEL_W);
    if (raw > 32'(led_n)) return LEVEL_W'(led_n);
    return raw[LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/adc_block_avg.sv
// adc_block_avg
// Boxcar averager: sums blocks of 2^AVG_LOG2 accepted samples and publishes
// the truncated mean.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   s_valid, s_data  : sample strobe and unsigned sample
//   enable           : when low, strobes are ignored and the partial block kept
//   clear            : soft clear of the partial block (avg_data is kept)
//   avg_valid        : one-cycle pulse when avg_data updates
//   avg_data         : latest block average
// Handshake: s_valid is a one-cycle strobe with no back-pressure; a sample is
// consumed on every clock where s_valid & enable & !clear is high.
module adc_block_avg #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              enable,
  input  logic              clear,
  output logic              avg_valid,
  output logic [DATA_W-1:0] avg_data
);

  // Wide enough to hold 2^AVG_LOG2 full-scale samples without overflow.
  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc;
  logic [AVG_LOG2-1:0] cnt;
  logic [ACC_W-1:0]    sum;
  logic                accept;

  assign accept = s_valid & enable & ~clear;
  assign sum    = acc + ACC_W'(s_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      avg_valid <= 1'b0;
      avg_data  <= '0;
    end else if (clear) begin
      acc       <= '0;
      cnt       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (accept) begin
        // cnt all-ones means this sample completes the block.
        if (cnt == '1) begin
          avg_data  <= sum[ACC_W-1:AVG_LOG2];
          avg_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_level_meter.sv
// adc_level_meter
// Averages the ADC sample stream in blocks and drives a bar graph with a
// peak-hold marker on the LED bank.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   s_valid, s_data : sample strobe and unsigned sample from the ADC stage
//   enable          : when low, samples are ignored (partial block kept)
//   clear           : soft clear of averager, peak FSM and LEDs
//   avg_valid       : one-cycle pulse when avg_data updates
//   avg_data        : latest block average
//   leds            : bar graph OR'ed with the peak marker
//   peak_level      : current peak level, 0..LED_N
// Handshake: s_valid is a one-cycle strobe with no back-pressure; a sample is
// consumed on every clock where s_valid & enable & !clear is high.
// The peak FSM state is held in the signal 'state' for observation.
module adc_level_meter
  import adc_meter_pkg::*;
#(
  parameter int DATA_W       = 12,
  parameter int AVG_LOG2     = 4,
  parameter int LED_N        = 12,
  parameter int HOLD_CYCLES  = 50000000,
  parameter int DECAY_CYCLES = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               enable,
  input  logic               clear,
  output logic               avg_valid,
  output logic [DATA_W-1:0]  avg_data,
  output logic [LED_N-1:0]   leds,
  output logic [LEVEL_W-1:0] peak_level
);

  localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int DECAY_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_CYCLES - 1);

  adc_block_avg #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .enable    (enable),
    .clear     (clear),
    .avg_valid (avg_valid),
    .avg_data  (avg_data)
  );

  peak_state_t          state, nxt_state;
  logic [LEVEL_W-1:0]   level_q, new_level;
  logic [LEVEL_W-1:0]   nxt_peak;
  logic [HOLD_W-1:0]    hold_cnt, nxt_hold;
  logic [DECAY_W-1:0]   decay_cnt, nxt_decay;
  logic [LED_N-1:0]     nxt_leds;

  // The level register takes the new block average in the cycle avg_valid is
  // high; the peak logic and LEDs see that new level on the same edge, so the
  // display lands two clocks after the last sample of a block.
  assign new_level = avg_valid ? level_of(32'(avg_data), DATA_W, LED_N) : level_q;

  always_comb begin
    nxt_state = state;
    nxt_peak  = peak_level;
    nxt_hold  = hold_cnt;
    nxt_decay = decay_cnt;

    // A higher level restarts the hold from any state and outranks counters.
    if (new_level > peak_level) begin
      nxt_peak  = new_level;
      nxt_state = HOLD;
      nxt_hold  = '0;
    end else begin
      case (state)
        TRACK: nxt_peak = new_level;
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            nxt_state = DECAY;
            nxt_decay = '0;
          end else begin
            nxt_hold = hold_cnt + 1'b1;
          end
        end
        DECAY: begin
          if (decay_cnt == DECAY_LAST) begin
            nxt_decay = '0;
            if (peak_level > new_level) nxt_peak = peak_level - 1'b1;
            else                        nxt_peak = new_level;
          end else begin
            nxt_decay = decay_cnt + 1'b1;
          end
          // Once the marker has come down to the bar, resume tracking.
          if (nxt_peak == new_level) nxt_state = TRACK;
        end
        default: nxt_state = TRACK;
      endcase
    end

    nxt_leds = '0;
    for (int k = 0; k < LED_N; k++) begin
      nxt_leds[k] = (LEVEL_W'(k) < new_level) || (nxt_peak == LEVEL_W'(k + 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state      <= TRACK;
      level_q    <= '0;
      peak_level <= '0;
      hold_cnt   <= '0;
      decay_cnt  <= '0;
      leds       <= '0;
    end else begin
      state      <= nxt_state;
      level_q    <= new_level;
      peak_level <= nxt_peak;
      hold_cnt   <= nxt_hold;
      decay_cnt  <= nxt_decay;
      leds       <= nxt_leds;
    end
  end

endmodule

// File: tb/tb_adc_level_meter.sv
// tb_adc_level_meter
// Directed scenarios followed by randomized traffic; every clock the DUT
// outputs are compared with a behavioural model of the meter.
module tb_adc_level_meter;
  import adc_meter_pkg::*;

  localparam int DATA_W       = 12;
  localparam int AVG_LOG2     = 2;
  localparam int LED_N        = 12;
  localparam int HOLD_CYCLES  = 8;
  localparam int DECAY_CYCLES = 4;
  localparam int BLOCK        = 1 << AVG_LOG2;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               s_valid = 1'b0;
  logic [DATA_W-1:0]  s_data = '0;
  logic               enable = 1'b1;
  logic               clear = 1'b0;
  logic               avg_valid;
  logic [DATA_W-1:0]  avg_data;
  logic [LED_N-1:0]   leds;
  logic [LEVEL_W-1:0] peak_level;

  always #5 clk = ~clk;

  adc_level_meter #(
    .DATA_W       (DATA_W),
    .AVG_LOG2     (AVG_LOG2),
    .LED_N        (LED_N),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .DECAY_CYCLES (DECAY_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .enable     (enable),
    .clear      (clear),
    .avg_valid  (avg_valid),
    .avg_data   (avg_data),
    .leds       (leds),
    .peak_level (peak_level)
  );

  // ---------------- scoreboard ----------------
  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      if (err_cnt <= 30)
        $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending samples of the current block, last average, displayed level and
  // peak, plus the number of clocks spent in the current peak mode.
  logic [DATA_W-1:0] exp_q[$];
  int          m_avg_valid = 0;
  int          m_avg_data  = 0;
  int          m_level     = 0;
  int          m_peak      = 0;
  int          m_leds      = 0;
  int          m_age       = 0;
  peak_state_t m_mode      = TRACK;

  task automatic model_reset_meter();
    exp_q.delete();
    m_avg_valid = 0;
    m_level     = 0;
    m_peak      = 0;
    m_leds      = 0;
    m_age       = 0;
    m_mode      = TRACK;
  endtask

  task automatic model_edge(input logic v, input logic [DATA_W-1:0] d,
                            input logic en, input logic clr, input logic rst);
    int lvl;
    int sum;
    if (rst) begin
      model_reset_meter();
      m_avg_data = 0;
    end else if (clr) begin
      model_reset_meter();
    end else begin
      // Display path sees the average published in the previous cycle.
      lvl = m_avg_valid ? (m_avg_data >> (DATA_W - 4)) : m_level;
      if (lvl > LED_N) lvl = LED_N;

      if (lvl > m_peak) begin
        m_peak = lvl;
        m_mode = HOLD;
        m_age  = 0;
      end else if (m_mode == TRACK) begin
        m_peak = lvl;
      end else if (m_mode == HOLD) begin
        m_age++;
        if (m_age == HOLD_CYCLES) begin
          m_mode = DECAY;
          m_age  = 0;
        end
      end else begin
        m_age++;
        if (m_age == DECAY_CYCLES) begin
          m_age  = 0;
          m_peak = (m_peak > lvl) ? m_peak - 1 : lvl;
        end
        if (m_peak == lvl) m_mode = TRACK;
      end
      m_level = lvl;
      m_leds  = ((1 << lvl) - 1) | ((m_peak > 0) ? (1 << (m_peak - 1)) : 0);

      // Averager: mean of the last BLOCK accepted samples.
      m_avg_valid = 0;
      if (v && en) begin
        exp_q.push_back(d);
        if (exp_q.size() == BLOCK) begin
          sum = 0;
          foreach (exp_q[i]) sum += int'(exp_q[i]);
          m_avg_data  = sum / BLOCK;
          m_avg_valid = 1;
          exp_q.delete();
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [DATA_W-1:0] d,
                      input logic en, input logic clr, input logic rst);
    s_valid = v;
    s_data  = d;
    enable  = en;
    clear   = clr;
    reset   = rst;
    @(posedge clk);
    model_edge(v, d, en, clr, rst);
    @(negedge clk);
    check_eq("avg_valid",  32'(avg_valid),  32'(m_avg_valid));
    check_eq("avg_data",   32'(avg_data),   32'(m_avg_data));
    check_eq("leds",       32'(leds),       32'(m_leds));
    check_eq("peak_level", 32'(peak_level), 32'(m_peak));
    check_eq("state",      32'(dut.state),  32'(m_mode));
  endtask

  task automatic sample(input logic [DATA_W-1:0] d);
    step(1'b1, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int amp;
    logic [DATA_W-1:0] t1 [4];
    t1[0] = 12'h100; t1[1] = 12'h200; t1[2] = 12'h300; t1[3] = 12'h400;

    // Reset state
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check_eq("rst_avg_valid", 32'(avg_valid), 32'h0);
    check_eq("rst_avg_data",  32'(avg_data),  32'h0);
    check_eq("rst_leds",      32'(leds),      32'h0);
    check_eq("rst_peak",      32'(peak_level), 32'h0);
    check_eq("rst_state",     32'(dut.state), 32'(TRACK));
    idle(2);

    // 1: ramp block
    for (int i = 0; i < 4; i++) sample(t1[i]);
    check_eq("t1_avg_valid", 32'(avg_valid), 32'h1);
    check_eq("t1_avg_data",  32'(avg_data),  32'h280);
    idle(1);
    check_eq("t1_leds", 32'(leds), 32'h003);
    check_eq("t1_peak", 32'(peak_level), 32'd2);

    // 2: full scale, level clamps to LED_N
    for (int i = 0; i < 4; i++) sample(12'hFFF);
    check_eq("t2_avg_data", 32'(avg_data), 32'hFFF);
    // 3: drop to zero, marker holds then decays
    for (int i = 0; i < 4; i++) sample(12'h000);
    idle(1);
    check_eq("t3_leds_hold", 32'(leds), 32'h800);
    check_eq("t3_peak_hold", 32'(peak_level), 32'd12);
    idle(60);
    check_eq("t3_leds_end",  32'(leds), 32'h000);
    check_eq("t3_peak_end",  32'(peak_level), 32'd0);
    check_eq("t3_state_end", 32'(dut.state), 32'(TRACK));

    // 4: clear with the 4th sample drops the block
    for (int i = 0; i < 3; i++) sample(12'h300);
    step(1'b1, 12'h300, 1'b1, 1'b1, 1'b0);
    idle(1);
    check_eq("t4_no_valid", 32'(avg_valid), 32'h0);
    for (int i = 0; i < 4; i++) sample(12'h040);
    check_eq("t4_avg_valid", 32'(avg_valid), 32'h1);
    check_eq("t4_avg_data",  32'(avg_data),  32'h040);
    idle(1);
    check_eq("t4_leds", 32'(leds), 32'h000);

    // 5: enable low retains the partial block
    sample(12'h800);
    sample(12'h800);
    for (int i = 0; i < 3; i++) step(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0);
    sample(12'h800);
    sample(12'h800);
    check_eq("t5_avg_data", 32'(avg_data), 32'h800);
    idle(1);
    check_eq("t5_leds", 32'(leds), 32'h0FF);

    // 6: reset during HOLD and mid-block
    for (int i = 0; i < 4; i++) sample(12'hFFF);
    idle(2);
    check_eq("t6_peak_pre", 32'(peak_level), 32'd12);
    sample(12'hFFF);
    sample(12'hFFF);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check_eq("t6_leds_rst",  32'(leds), 32'h0);
    check_eq("t6_peak_rst",  32'(peak_level), 32'd0);
    check_eq("t6_state_rst", 32'(dut.state), 32'(TRACK));
    for (int i = 0; i < 4; i++) sample(12'h100);
    check_eq("t6_avg_data", 32'(avg_data), 32'h100);
    idle(1);
    check_eq("t6_leds", 32'(leds), 32'h001);

    // Randomized traffic with a slowly changing amplitude envelope
    amp = 4095;
    for (int i = 0; i < 2500; i++) begin
      if (i % 64 == 0) amp = $urandom_range(0, 4095);
      step(($urandom_range(0, 9) < 6),
           DATA_W'($urandom_range(0, amp)),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 199) == 0));
    end
    idle(80);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
